// File: rtl/line_fill_writer.sv
// rtl/line_fill_writer.sv - assembles fill-bus beats into a cache line and writes it to one way
// Optional abort input is compiled in when LINE_FILL_ABORT_EN is defined.
module line_fill_writer #(
  parameter int ways      = 8,
  parameter int lineSize  = 512,
  parameter int beatWidth = 64
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       start,
  input  logic [((ways > 1) ? $clog2(ways) : 1)-1:0] select,
  input  logic                                       beatValid,
  input  logic [beatWidth-1:0]                       beatData,
`ifdef LINE_FILL_ABORT_EN
  input  logic                                       abort,
`endif
  output logic                                       beatReady,
  output logic [ways-1:0]                            we,
  output logic [lineSize-1:0]                        lineOut,
  output logic                                       busy,
  output logic                                       done
);

  localparam int SEL_W = (ways > 1) ? $clog2(ways) : 1;
  localparam int BEATS = lineSize / beatWidth;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [SEL_W-1:0]    r_way;
  logic [CNT_W-1:0]    r_cnt;
  logic [lineSize-1:0] r_line;
  logic                w_abort;
  logic                w_xfer;
  logic                w_last;

`ifdef LINE_FILL_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // A beat is consumed only in FILL, and an abort suppresses even the final beat.
  assign w_xfer  = (r_state == FILL) && beatValid && !w_abort;
  assign w_last  = (r_cnt == CNT_W'(BEATS - 1));
  assign lineOut = r_line;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and output decode; outputs depend on state only, so reset clears them at once.
  always_comb begin
    w_next    = r_state;
    beatReady = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    we        = '0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = FILL;
        end
      end
      FILL: begin
        beatReady = 1'b1;
        busy      = 1'b1;
        if (w_abort) begin
          w_next = IDLE;
        end else if (w_xfer && w_last) begin
          w_next = WRITE;
        end
      end
      WRITE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = IDLE;
        // An out-of-range way matches no bit, leaving we all zero.
        for (int i = 0; i < ways; i++) begin
          we[i] = (r_way == SEL_W'(i));
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Way latch, beat counter and line assembly; the line holds between fills.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_way  <= '0;
      r_cnt  <= '0;
      r_line <= '0;
    end else begin
      if ((r_state == IDLE) && start) begin
        r_way <= select;
        r_cnt <= '0;
      end else if (w_xfer) begin
        for (int k = 0; k < BEATS; k++) begin
          if (r_cnt == CNT_W'(k)) begin
            r_line[k*beatWidth +: beatWidth] <= beatData;
          end
        end
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule
